// File: rtl/data_memory_ctrl.sv
// Byte-addressed, big-endian data memory with a fixed-latency request/complete handshake.
// A single access is in flight at a time. Faulting accesses complete normally but never touch storage.
module data_memory_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int LATENCY     = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              se,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              valid,
  output logic [31:0]       rdata,
  output logic              fault
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rw_q, se_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] a0;
  logic [31:0]       wdata_q;

  logic [7:0]        mem [DEPTH];

  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic              flt, do_acc, do_wr;
  logic [31:0]       rd_val;

  // Address arithmetic is ADDR_W wide, so multi-byte accesses wrap at the top of memory.
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  assign ready  = (state == IDLE);
  assign do_acc = (state == BUSY) && (cnt == 4'd1);
  assign do_wr  = do_acc && rw_q && !flt && !reset;

  always_comb begin
    flt = (size_q == 2'b11);
    if (ALIGN_CHECK != 0) begin
      if (size_q == 2'b01 && a0[0])          flt = 1'b1;
      if (size_q == 2'b10 && a0[1:0] != 2'b00) flt = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    case (size_q)
      2'b00:   rd_val = se_q ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   rd_val = se_q ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      default: rd_val = {b0, b1, b2, b3};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      valid   <= 1'b0;
      fault   <= 1'b0;
      rdata   <= '0;
      rw_q    <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= '0;
      a0      <= '0;
      wdata_q <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state   <= BUSY;
            cnt     <= LAT;
            rw_q    <= rw;
            se_q    <= se;
            size_q  <= size;
            a0      <= addr;
            wdata_q <= wdata;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            valid <= 1'b1;
            fault <= flt;
            rdata <= (flt || rw_q) ? 32'h0 : rd_val;
          end
        end
      endcase
    end
  end

  // Storage has no reset: reset must never disturb its contents.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      case (size_q)
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        default: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
      endcase
    end
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, byte-address width; depth = 2**ADDR_W bytes.
REQ-002 The module SHALL have parameter LATENCY, default 1, clock edges from request acceptance to the data-returning edge; legal range 1..15.
REQ-003 The module SHALL have parameter ALIGN_CHECK, default 1; 1 = misaligned halfword/word access faults, 0 = unaligned access allowed with byte wrap.
REQ-004 The module SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The module SHALL have port req, input, 1, access request.
REQ-007 The module SHALL have port rw, input, 1, 0 = read, 1 = write.
REQ-008 The module SHALL have port size, input, 2, 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-009 The module SHALL have port se, input, 1, sign-extend byte/halfword reads.
REQ-010 The module SHALL have port addr, input, ADDR_W, byte address.
REQ-011 The module SHALL have port wdata, input, 32, write data, right-justified.
REQ-012 The module SHALL have port ready, output, 1, high when a request can be accepted.
REQ-013 The module SHALL have port valid, output, 1, one-cycle completion pulse.
REQ-014 The module SHALL have port rdata, output, 32, read result, qualified by valid.
REQ-015 The module SHALL have port fault, output, 1, access error, qualified by valid.

Function
REQ-016 Storage SHALL be a 2**ADDR_W x 8 byte array, big-endian: the byte at addr is most significant.
REQ-017 The FSM SHALL have two states: IDLE and BUSY; ready SHALL equal (state == IDLE).
REQ-018 A request SHALL be accepted on a rising edge where ready = 1 and req = 1; rw, size, se, addr and wdata SHALL be captured on that edge; req while BUSY SHALL be ignored.
REQ-019 On acceptance, state SHALL go to BUSY with a wait counter loaded to LATENCY.
REQ-020 The counter SHALL decrement by 1 every edge in BUSY.
REQ-021 On the edge where the counter equals 1, the access SHALL be performed, valid SHALL be registered high, and state SHALL return to IDLE.
REQ-022 valid SHALL therefore be high exactly in the cycle after edge N+LATENCY, where N is the accepting edge.
REQ-023 A new request SHALL be acceptable on the edge that ends the valid cycle (back-to-back throughput = one access per LATENCY+1 cycles).
REQ-024 Reads SHALL return: byte = Mem[a]; half = {Mem[a], Mem[a+1]}; word = {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}.
REQ-025 Byte and halfword reads SHALL be zero-extended when se = 0 and sign-extended from bit 7 or bit 15 when se = 1; se SHALL be ignored for words and writes.
REQ-026 Writes SHALL store the low 8/16/32 bits of wdata big-endian at a.. and SHALL return rdata = 0.
REQ-027 Byte offsets SHALL be computed modulo 2**ADDR_W (wrap-around at top of memory).
REQ-028 A fault SHALL be raised for size = 11, and, when ALIGN_CHECK = 1, for a halfword with addr[0] = 1 or a word with addr[1:0] != 0.
REQ-029 A faulting access SHALL leave memory unmodified, SHALL still complete with normal latency, and SHALL drive valid = 1, fault = 1, rdata = 0.
REQ-030 rdata and fault SHALL hold their value until the next completion; valid SHALL be high for exactly one cycle.
REQ-031 A read completing after a write to the same address SHALL return the written data (no hazard, since accesses are serialised).

Reset
REQ-032 While reset is high: state = IDLE, counter = 0, ready = 1, valid = 0, fault = 0, rdata = 0, asynchronously.
REQ-033 Reset asserted while BUSY SHALL abort the access: no memory write and no valid pulse.
REQ-034 Memory contents SHALL NOT be altered by reset and SHALL be zero at time 0.

Verification
REQ-035 Word write then read, LATENCY = 1: write 0xDEADBEEF @0x10, then read word @0x10 -> valid one cycle after the second edge, rdata = 0xDEADBEEF, fault = 0; byte read @0x11 -> 0x000000AD.
REQ-036 Sign extension: halfword read @0x10 with se = 1 -> 0xFFFFDEAD, with se = 0 -> 0x0000DEAD; byte read @0x13 with se = 1 -> 0xFFFFFFEF.
REQ-037 Misalignment, ALIGN_CHECK = 1: word write @0x21 -> valid, fault = 1, rdata = 0; a subsequent word read @0x20 returns the prior contents unchanged; size = 11 -> fault = 1.
REQ-038 Wrap, ALIGN_CHECK = 0, ADDR_W = 8: word write 0x11223344 @0xFE -> Mem[0xFE] = 0x11, Mem[0xFF] = 0x22, Mem[0x00] = 0x33, Mem[0x01] = 0x44.
REQ-039 LATENCY = 4 with back-to-back req held high -> ready low for 4 cycles per access, valid pulses every 5 cycles, and req while BUSY is ignored.
REQ-040 Reset mid-access: assert reset two cycles after accepting a write of 0xA5 @0x30 with LATENCY = 4 -> no valid pulse, ready = 1; a later read @0x30 returns the pre-write value.
